pe_window_requant: RTL and testbench
====================================

Name: pe_window_requant

Overview:
- Downstream drain stage for one systolic MAC PE (mac_pe) whose accumulator never clears and advances only on valid beats.
- Tracks PE valid beats and snapshots the 32-bit accumulator at each window boundary.
- Differences consecutive snapshots to recover per-window dot products, then requantizes each to INT8 (scale, rounded shift, saturate).
- Results leave through a 2-entry valid/ready output FIFO toward the writeback path.

Parameters:
- WINDOW_LEN, 16, products per output window; legal range 1..65535.
- PE_LAT, 2, PE valid beats between a feature entering and its product reaching the accumulator; fixed by the PE's A/B→M→P register chain.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pe_valid  input  1  same signal driving the PE valid_in; one beat per high cycle
- accum_in  input  32  PE accum_out, two's-complement, wraps modulo 2^32
- scale  input  16  unsigned requant multiplier; quasi-static, change only when idle
- shift  input  5  arithmetic right shift, 0..31; quasi-static
- res_valid  output  1  FIFO head valid
- res_ready  input  1  consumer accept
- res_data  output  8  signed INT8 result
- res_sat  output  1  head result was clipped
- overflow  output  1  sticky; a result was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync deassert by the reset tree): counters 0, warmup state, snapshot 0, pipeline valids 0, FIFO empty. Outputs after reset: res_valid=0, res_data=0, res_sat=0, overflow=0. Reset must be shared with the PE so both accumulators start at 0.
- FSM:
  - WARMUP: counts PE_LAT pe_valid beats, then goes to RUN. These beats carry no window product.
  - RUN: beat counter runs 1..WINDOW_LEN. The beat that reaches WINDOW_LEN is the completing beat (cycle T); the counter wraps to 0 on it. There is no return to WARMUP except via reset.
  - PE_LAT=0 skips WARMUP.
- Capture, cycle T+1 (independent of pe_valid in T+1):
  - diff = accum_in - snapshot, 32-bit modular; correct whenever the true window sum fits in signed 32 bits.
  - snapshot <= accum_in.
  - Stage-1 register holds diff.
- Stage 2, registered at end of T+2: prod = diff × {0,scale}, signed, 49 bits.
- Stage 3, registered at end of T+3:
  - If shift > 0, add 2^(shift-1) to prod (round half toward +inf).
  - Arithmetic right shift by shift.
  - Saturate to [-128, 127]; res_sat=1 if clipped.
  - The result is written into the FIFO.
- Latency: with the FIFO empty, res_valid rises in cycle T+4.
- Pipeline: fully pipelined; a new window may complete every WINDOW_LEN cycles, including WINDOW_LEN=1 (one result per beat).
- Gaps: pe_valid low freezes the beat counter; pending pipeline stages still advance. PE gaps therefore never corrupt results.
- Stream end: the producer must append PE_LAT zero-feature beats after the final window's last feature. This block generates no flush beats.
- FIFO:
  - 2 entries, first-word fall-through.
  - Pop on res_valid & res_ready.
  - Push and pop in the same cycle with the FIFO full is legal: no drop.
  - Push when full with no pop: drop the new result, set overflow=1. overflow clears only on reset.
  - res_data and res_sat hold stable while res_valid=1 and res_ready=0.
  - res_data=0 and res_sat=0 when the FIFO is empty.
- Reset mid-window: all progress is discarded; the first window after reset again needs PE_LAT+WINDOW_LEN beats.

Test Plan:
- WINDOW_LEN=4, PE_LAT=2, weight=2, scale=1, shift=0; features 1,2,3,4,5,6,7,8,0,0 back-to-back, res_ready=1 -> res_data 20 then 52, res_sat=0. First res_valid 4 cycles after the 6th beat.
- Same stimulus, pe_valid with random idle gaps (~50% duty) -> identical results 20, 52. No spurious res_valid.
- Rounding:
  - window sum 20, scale=3, shift=3 -> 60/8=7.5 -> 8.
  - window sum -20 (weight -2), same scale/shift -> -7.5 -> -7.
- Saturation: weight=127, four features of 127 (sum 64516), scale=1, shift=0 -> res_data=127, res_sat=1. Weight=-128, features 127×4 -> -128, res_sat=1.
- Backpressure: res_ready=0, three windows complete -> first two retained in order, third dropped, overflow=1 and sticky. Raising res_ready drains exactly two results.
- Reset mid-window: assert rst_n low after 3 beats of a window, release, then run the first scenario -> results 20, 52; overflow=0 and res_valid=0 during and immediately after reset.

Source files
------------

// File: rtl/pe_window_requant.sv
// Drain stage for a free-running MAC PE accumulator: snapshots the accumulator at window
// boundaries, differences consecutive snapshots, requantizes to INT8 and queues the result.
`timescale 1ns/1ps
module pe_window_requant #(
    parameter int WINDOW_LEN = 16,
    parameter int PE_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pe_valid,
    input  logic [31:0]       accum_in,
    input  logic [15:0]       scale,
    input  logic [4:0]        shift,
    output logic              res_valid,
    input  logic              res_ready,
    output logic signed [7:0] res_data,
    output logic              res_sat,
    output logic              overflow
);
    localparam int DATA_W = 32;
    localparam int COEF_W = 16;
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int RND_W  = PROD_W + 1;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_WARM = CNT_W'(PE_LAT - 1);

    typedef enum logic {ST_WARMUP, ST_RUN} state_t;
    localparam state_t RST_STATE = (PE_LAT == 0) ? ST_RUN : ST_WARMUP;

    function automatic logic signed [RND_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] p,
        input logic [4:0]               sh
    );
        logic signed [RND_W-1:0] r;
        r = RND_W'(p);
        if (sh != 5'd0)
            r = r + (RND_W'(1) <<< (sh - 5'd1));
        return r >>> sh;
    endfunction

    function automatic logic [8:0] saturate(input logic signed [RND_W-1:0] q);
        if (q > RND_W'(127))
            return {1'b1, 8'h7F};
        else if (q < -RND_W'(128))
            return {1'b1, 8'h80};
        else
            return {1'b0, q[7:0]};
    endfunction

    state_t                    r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_warm_cnt, w_warm_nxt;
    logic [CNT_W-1:0]          r_beat_cnt, w_beat_nxt;
    logic                      w_complete;

    logic                      r_vld_p0, r_vld_p1, r_vld_p2;
    logic [DATA_W-1:0]         r_snap;
    logic signed [DATA_W-1:0]  r_diff_p1;
    logic signed [PROD_W-1:0]  r_prod_p2;
    logic [8:0]                w_rq;

    logic [8:0]                r_fifo [2];
    logic [1:0]                r_count;
    logic                      r_wr_ptr, r_rd_ptr;
    logic                      r_overflow;
    logic                      w_push, w_pop, w_full, w_accept;
    logic [8:0]                w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RST_STATE;
            r_warm_cnt <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_warm_nxt  = r_warm_cnt;
        w_beat_nxt  = r_beat_cnt;
        w_complete  = 1'b0;
        case (r_state)
            ST_WARMUP: begin
                if (pe_valid) begin
                    if (r_warm_cnt == LAST_WARM) begin
                        w_state_nxt = ST_RUN;
                        w_warm_nxt  = '0;
                    end else begin
                        w_warm_nxt = r_warm_cnt + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (pe_valid) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_beat_nxt = '0;
                        w_complete = 1'b1;
                    end else begin
                        w_beat_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = RST_STATE;
        endcase
    end

    // p0 -> p1: capture the boundary accumulator, p1 -> p2: scale, p2 -> FIFO: round/shift/saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_snap   <= '0;
        end else begin
            r_vld_p0 <= w_complete;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p0)
                r_snap <= accum_in;
        end
    end

    always_ff @(posedge clk) begin
        if (r_vld_p0)
            r_diff_p1 <= $signed(accum_in - r_snap);
        if (r_vld_p1)
            r_prod_p2 <= PROD_W'(r_diff_p1) * PROD_W'($signed({1'b0, scale}));
    end

    assign w_rq     = saturate(round_shift(r_prod_p2, shift));
    assign w_push   = r_vld_p2;
    assign w_pop    = res_valid & res_ready;
    assign w_full   = (r_count == 2'd2);
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_accept = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push & w_full & ~w_pop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_fifo[r_wr_ptr] <= w_rq;
    end

    assign w_head              = r_fifo[r_rd_ptr];
    assign res_valid           = (r_count != 2'd0);
    assign {res_sat, res_data} = res_valid ? w_head : 9'd0;
    assign overflow            = r_overflow;

endmodule

// File: tb/tb_pe_window_requant.sv
// Bench for pe_window_requant: a behavioural MAC PE feeds the block, a scoreboard queue
// holds expected INT8 results and a negedge monitor compares every accepted result.
`timescale 1ns/1ps
module tb_pe_window_requant;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              pe_valid;
    logic [31:0]       accum_in;
    logic [15:0]       scale;
    logic [4:0]        shift;
    logic              res_valid;
    logic              res_ready;
    logic signed [7:0] res_data;
    logic              res_sat;
    logic              overflow;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic signed [7:0] d;
        logic              s;
    } exp_t;
    exp_t sb_q[$];

    logic signed [31:0] pe_feat, pe_w, pe_a, pe_m, pe_acc;
    int feats[$];

    always #5 clk = ~clk;

    pe_window_requant #(.WINDOW_LEN(4), .PE_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .pe_valid(pe_valid), .accum_in(accum_in),
        .scale(scale), .shift(shift), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_sat(res_sat), .overflow(overflow)
    );

    // Behavioural mac_pe: A/B register, M register, accumulating P register, all on valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_a   <= '0;
            pe_m   <= '0;
            pe_acc <= '0;
        end else if (pe_valid) begin
            pe_a   <= pe_feat;
            pe_m   <= pe_a * pe_w;
            pe_acc <= pe_acc + pe_m;
        end
    end
    assign accum_in = pe_acc;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            chk("result_expected", (sb_q.size() > 0) ? 32'sd1 : 32'sd0, 32'sd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("res_data", res_data, e.d);
                chk("res_sat", res_sat, e.s);
            end
        end
    end

    task automatic push_exp(input logic signed [7:0] d, input logic s);
        sb_q.push_back('{d: d, s: s});
    endtask

    task automatic step(input logic v, input logic signed [31:0] f);
        pe_valid = v;
        pe_feat  = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'sd0);
    endtask

    task automatic play(input bit gaps);
        foreach (feats[i]) begin
            if (gaps) idle($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 2));
            step(1'b1, feats[i]);
        end
    endtask

    task automatic set_feats(input int first, input int last, input int zeros);
        feats.delete();
        for (int v = first; v <= last; v++) feats.push_back(v);
        for (int z = 0; z < zeros; z++) feats.push_back(0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb_q.size() > 0; i++) step(1'b0, 32'sd0);
        idle(6);
        chk(tag, sb_q.size(), 32'sd0);
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        pe_valid  = 1'b0;
        pe_feat   = '0;
        pe_w      = 32'sd2;
        scale     = 16'd1;
        shift     = 5'd0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_sat", res_sat, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back windows with latency check after the 6th beat.
        push_exp(8'sd20, 1'b0);
        push_exp(8'sd52, 1'b0);
        for (int f = 1; f <= 6; f++) step(1'b1, f);
        step(1'b1, 32'sd7);
        chk("lat_t1_valid", res_valid, 0);
        step(1'b1, 32'sd8);
        chk("lat_t2_valid", res_valid, 0);
        step(1'b1, 32'sd0);
        chk("lat_t3_valid", res_valid, 1);
        chk("lat_t3_data", res_data, 20);
        step(1'b1, 32'sd0);
        drain("drain_b2b");

        // Same stream with random idle gaps.
        do_reset();
        push_exp(8'sd20, 1'b0);
        push_exp(8'sd52, 1'b0);
        set_feats(1, 8, 2);
        play(1'b1);
        drain("drain_gaps");

        // Rounding half toward +inf, positive and negative.
        do_reset();
        scale = 16'd3;
        shift = 5'd3;
        push_exp(8'sd8, 1'b0);
        set_feats(1, 4, 2);
        play(1'b0);
        drain("drain_round_pos");
        do_reset();
        pe_w = -32'sd2;
        push_exp(-8'sd7, 1'b0);
        play(1'b0);
        drain("drain_round_neg");

        // Saturation at both rails.
        do_reset();
        scale = 16'd1;
        shift = 5'd0;
        pe_w  = 32'sd127;
        push_exp(8'sd127, 1'b1);
        feats.delete();
        for (int i = 0; i < 4; i++) feats.push_back(127);
        feats.push_back(0);
        feats.push_back(0);
        play(1'b0);
        drain("drain_sat_pos");
        do_reset();
        pe_w = -32'sd128;
        push_exp(-8'sd128, 1'b1);
        play(1'b0);
        drain("drain_sat_neg");

        // Backpressure: three windows into a stalled 2-entry FIFO.
        do_reset();
        pe_w      = 32'sd1;
        res_ready = 1'b0;
        push_exp(8'sd10, 1'b0);
        push_exp(8'sd26, 1'b0);
        set_feats(1, 12, 2);
        play(1'b0);
        idle(6);
        chk("bp_overflow", overflow, 1);
        chk("bp_valid", res_valid, 1);
        chk("bp_head", res_data, 10);
        idle(3);
        chk("bp_head_hold", res_data, 10);
        chk("bp_sat_hold", res_sat, 0);
        res_ready = 1'b1;
        drain("drain_bp");
        chk("bp_empty_valid", res_valid, 0);
        chk("bp_empty_data", res_data, 0);
        chk("bp_empty_sat", res_sat, 0);
        chk("bp_overflow_sticky", overflow, 1);

        // Reset three beats into a window, then the baseline stream again.
        for (int f = 1; f <= 3; f++) step(1'b1, f);
        pe_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_valid", res_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_overflow", overflow, 0);
        chk("post_rst_valid", res_valid, 0);
        pe_w = 32'sd2;
        push_exp(8'sd20, 1'b0);
        push_exp(8'sd52, 1'b0);
        set_feats(1, 8, 2);
        play(1'b0);
        drain("drain_after_rst");
        chk("final_overflow", overflow, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
